one_counter_seq: RTL
====================

# one_counter_seq

Parametrised, multi-cycle population counter: accepts a WIDTH-bit word over a valid/ready handshake, counts its set bits (or clear bits, per mode) CHUNK bits per clock, and returns the count over a second valid/ready handshake. Successor to the 3-bit combinational one-counter. Sits between a word source and a consumer in area-constrained datapaths where a full combinational adder tree at large WIDTH is too costly.

## Interface
- WIDTH, 16, input word width in bits; ≥ 1.
- CHUNK, 4, bits counted per clock; 1 ≤ CHUNK ≤ WIDTH, WIDTH % CHUNK == 0 (elaboration-time check, fatal on violation).
- Derived (localparam): NCHUNK = WIDTH/CHUNK; CNT_W = $clog2(WIDTH+1); IDX_W = max(1, $clog2(NCHUNK)).

- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_mode valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to count.
- in_mode  input  1  0 = count ones, 1 = count zeros.
- out_valid  output  1  out_count valid.
- out_ready  input  1  consumer accepts out_count.
- out_count  output  CNT_W  resulting count, 0..WIDTH.
- busy  output  1  high in COUNT or DONE.

## Operation
- FSM states: IDLE, COUNT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch in_data (inverted if in_mode=1) into shift/data register, clear accumulator, clear chunk index, go to COUNT.
- COUNT: each cycle acc <= acc + popcount(chunk[idx]); idx increments. When idx == NCHUNK-1, that add is the last; go to DONE.
- DONE: out_valid=1, out_count=acc. Hold until out_ready; on out_valid&&out_ready go to IDLE.
- in_ready=1 only in IDLE; in_valid in COUNT/DONE is ignored (source must hold it). No back-to-back overlap.
- Chunk order LSB first: chunk k = bits [k*CHUNK +: CHUNK]. Order does not affect the result.
- Accumulator width CNT_W; cannot overflow (max WIDTH). Per-chunk popcount width $clog2(CHUNK+1), zero-extended before add.
- WIDTH == CHUNK: single COUNT cycle.
- in_mode=1, in_data all zeros → WIDTH.

## Timing
- Reset (any state, including mid-COUNT or DONE): next state IDLE; in_ready=1, out_valid=0, busy=0, out_count=0, acc=0, idx=0. Pending word is discarded, no output produced.
- Accept at edge T → COUNT during cycles T..T+NCHUNK-1 → out_valid=1 from edge T+NCHUNK. Latency = NCHUNK clocks.
- Output handshake at edge U → IDLE, in_ready=1 after U. Minimum word period NCHUNK+2 clocks (out_ready tied high).
- out_count and out_valid stable while out_ready=0; out_count holds last value in IDLE (not cleared until next accept).
- All outputs registered or decoded from state register only; no combinational path from in_valid/out_ready to outputs.

## Structure
- Package one_counter_pkg: state enum (IDLE, COUNT, DONE), cnt_width(w) function returning $clog2(w+1).
- Sub-module one_counter_chunk: combinational popcount of a CHUNK-bit vector, parameter CHUNK, output $clog2(CHUNK+1) bits; CHUNK=3 instance must match the legacy 3-bit counter truth table.
- Top: FSM, data register, idx counter, accumulator.

## Test plan
- WIDTH=16, CHUNK=4: in_data=16'h0000, mode 0 → out_count=0, out_valid rises exactly 4 clocks after accept.
- 16'hFFFF, mode 0 → 16 (CNT_W=5, no wrap); 16'h8001, mode 1 → 14.
- Backpressure: out_ready low 10 cycles after out_valid → out_count, out_valid stable; in_valid high meanwhile ignored, in_ready=0.
- rst asserted at 2nd COUNT cycle → next cycle IDLE, in_ready=1, out_valid=0; following word 16'h00F0 → 4 with no corruption.
- Configurations (WIDTH,CHUNK) = (3,3), (3,1), (32,8), (64,16): 20000 random words and modes vs behavioural popcount model; any mismatch prints both values and stops; CHUNK=3 sub-module checked exhaustively (8 vectors).

Source files
------------

// File: rtl/one_counter_pkg.sv
// Shared types and width helpers for the sequential population counter.
// State encoding and the count-width rule used by the top, interface and chunk counter.
package one_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/one_counter_seq_if.sv
// Word-in / count-out handshake bundle for one_counter_seq.
// master = word source and count consumer, slave = the counter.
interface one_counter_seq_if
    import one_counter_pkg::*;
#(
    parameter int WIDTH = 16
);
    localparam int CNT_W = cnt_width(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_count, busy
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_count, busy
    );

endinterface

// File: rtl/one_counter_chunk.sv
// Combinational popcount of one CHUNK-bit slice.
// At CHUNK=3 this reproduces the original 3-bit one-counter.
module one_counter_chunk
    import one_counter_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0]              bits,
    output logic [cnt_width(CHUNK)-1:0]   count
);

    localparam int PC_W = cnt_width(CHUNK);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + PC_W'(bits[i]);
        end
    end

endmodule

// File: rtl/one_counter_seq.sv
// Multi-cycle population counter: counts CHUNK bits of the latched word per clock.
//   state | meaning
//   IDLE  | in_ready=1, waiting for a word; out_count holds the previous result
//   COUNT | one chunk added to acc per clock, LSB chunk first
//   DONE  | out_valid=1, out_count=acc held until out_ready
module one_counter_seq
    import one_counter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst,
    one_counter_seq_if.slave  bus
);

    localparam int NCHUNK = WIDTH / ((CHUNK > 0) ? CHUNK : 1);
    localparam int CNT_W  = cnt_width(WIDTH);
    localparam int PC_W   = cnt_width(CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0 || $bits(bus.in_data) != WIDTH)
    begin : g_param_check
        $fatal(1, "one_counter_seq: illegal WIDTH/CHUNK combination");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_shift;
    logic [CNT_W-1:0] acc;
    logic [IDX_W-1:0] idx;
    logic [PC_W-1:0]  chunk_cnt;
    logic             last_chunk;

    one_counter_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .bits  (data_r[CHUNK-1:0]),
        .count (chunk_cnt)
    );

    // The word is shifted right so the chunk counter always sees the low slice.
    if (NCHUNK > 1) begin : g_shift
        assign data_shift = {{CHUNK{1'b0}}, data_r[WIDTH-1:CHUNK]};
    end else begin : g_noshift
        assign data_shift = data_r;
    end

    assign last_chunk    = (idx == IDX_W'(NCHUNK - 1));
    assign bus.out_count = acc;

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) state_nxt = COUNT;
            end
            COUNT: begin
                if (last_chunk) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            data_r <= '0;
            acc    <= '0;
            idx    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_r <= bus.in_mode ? ~bus.in_data : bus.in_data;
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                COUNT: begin
                    acc    <= acc + CNT_W'(chunk_cnt);
                    idx    <= idx + IDX_W'(1);
                    data_r <= data_shift;
                end
                default: ;
            endcase
        end
    end

endmodule
